// File: rtl/level_edge_filter.sv
// Glitch filter for a synchronized level: publishes a debounced level,
// one-cycle rise/fall pulses and a saturating accepted-edge count.
module level_edge_filter #(
  parameter int   FILT_CYC = 4,
  parameter int   CNT_W    = 8,
  parameter logic RST_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);
  localparam logic ONE_CYC = (FILT_CYC == 1);

  typedef enum logic [1:0] {
    LOW,
    CHK_H,
    HIGH,
    CHK_L
  } state_e;

  localparam state_e HOME = RST_LVL ? HIGH : LOW;

  state_e            state_q;
  logic [CW-1:0]     stab_q;
  logic              dout_q;
  logic              rise_q;
  logic              fall_q;
  logic              busy_q;
  logic [CNT_W-1:0]  edge_q;
  logic [CNT_W-1:0]  edge_d;
  logic              acc_r;
  logic              acc_f;

  always_comb begin
    acc_r = 1'b0;
    acc_f = 1'b0;
    case (state_q)
      LOW:   acc_r = din & ONE_CYC;
      CHK_H: acc_r = din & (stab_q == LAST);
      HIGH:  acc_f = ~din & ONE_CYC;
      CHK_L: acc_f = ~din & (stab_q == LAST);
      default: ;
    endcase
  end

  // Clear wins first, then a coincident accept counts on top of it.
  always_comb begin
    edge_d = edge_q;
    if (acc_r || acc_f) begin
      if (cnt_clr)
        edge_d = CNT_W'(1);
      else if (!(&edge_q))
        edge_d = edge_q + CNT_W'(1);
    end else if (cnt_clr) begin
      edge_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOME;
      stab_q  <= '0;
      dout_q  <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      edge_q  <= '0;
    end else begin
      rise_q <= acc_r;
      fall_q <= acc_f;
      edge_q <= edge_d;
      case (state_q)
        LOW: begin
          if (acc_r) begin
            state_q <= HIGH;
            dout_q  <= 1'b1;
          end else if (din) begin
            state_q <= CHK_H;
            stab_q  <= CW'(1);
            busy_q  <= 1'b1;
          end
        end
        CHK_H: begin
          if (!din) begin
            state_q <= LOW;
            stab_q  <= '0;
            busy_q  <= 1'b0;
          end else if (acc_r) begin
            state_q <= HIGH;
            stab_q  <= '0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            stab_q <= stab_q + CW'(1);
          end
        end
        HIGH: begin
          if (acc_f) begin
            state_q <= LOW;
            dout_q  <= 1'b0;
          end else if (!din) begin
            state_q <= CHK_L;
            stab_q  <= CW'(1);
            busy_q  <= 1'b1;
          end
        end
        CHK_L: begin
          if (din) begin
            state_q <= HIGH;
            stab_q  <= '0;
            busy_q  <= 1'b0;
          end else if (acc_f) begin
            state_q <= LOW;
            stab_q  <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            stab_q <= stab_q + CW'(1);
          end
        end
        default: begin
          state_q <= HOME;
          stab_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout     = dout_q;
  assign rise_pls = rise_q;
  assign fall_pls = fall_q;
  assign busy     = busy_q;
  assign edge_cnt = edge_q;

endmodule

// File: tb/tb_level_edge_filter.sv
// Bench for level_edge_filter: three parameterisations checked every
// cycle against a run-length model, plus directed literal checks.
module tb_level_edge_filter;

  logic clk;
  logic rst_n;
  logic [2:0] din_v;
  logic [2:0] clr_v;
  logic [2:0] dout_v, rise_v, fall_v, busy_v;
  logic [7:0] ec0, ec2;
  logic [1:0] ec1;

  int n_chk;
  int n_fail;
  bit chk_en;

  typedef struct {
    int lvl;
    int run;
    int rise;
    int fall;
    int cnt;
    int busy;
  } mst_t;

  localparam int FC [3] = '{4, 4, 1};
  localparam int MX [3] = '{255, 3, 255};
  localparam int RL [3] = '{0, 0, 1};

  mst_t m [3];
  int o_cnt [3];

  level_edge_filter #(.FILT_CYC(4), .CNT_W(8), .RST_LVL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_v[0]), .cnt_clr(clr_v[0]),
    .dout(dout_v[0]), .rise_pls(rise_v[0]), .fall_pls(fall_v[0]),
    .edge_cnt(ec0), .busy(busy_v[0]));

  level_edge_filter #(.FILT_CYC(4), .CNT_W(2), .RST_LVL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_v[1]), .cnt_clr(clr_v[1]),
    .dout(dout_v[1]), .rise_pls(rise_v[1]), .fall_pls(fall_v[1]),
    .edge_cnt(ec1), .busy(busy_v[1]));

  level_edge_filter #(.FILT_CYC(1), .CNT_W(8), .RST_LVL(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din_v[2]), .cnt_clr(clr_v[2]),
    .dout(dout_v[2]), .rise_pls(rise_v[2]), .fall_pls(fall_v[2]),
    .edge_cnt(ec2), .busy(busy_v[2]));

  assign o_cnt[0] = int'(ec0);
  assign o_cnt[1] = int'(ec1);
  assign o_cnt[2] = int'(ec2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A transition is accepted once fc consecutive samples differ from
  // the published level; any agreeing sample restarts the run.
  function automatic mst_t nxt(mst_t s, int d, int c, int fc, int mx);
    mst_t n;
    bit acc;
    n = s;
    acc = 1'b0;
    n.rise = 0;
    n.fall = 0;
    if (d != s.lvl) begin
      n.run = s.run + 1;
      if (n.run >= fc) begin
        acc = 1'b1;
        n.lvl = d;
        n.run = 0;
        n.rise = d;
        n.fall = 1 - d;
      end
    end else begin
      n.run = 0;
    end
    n.busy = (n.run != 0) ? 1 : 0;
    if (acc)
      n.cnt = (c != 0) ? 1 : ((s.cnt >= mx) ? mx : s.cnt + 1);
    else if (c != 0)
      n.cnt = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        m[i] <= '{RL[i], 0, 0, 0, 0, 0};
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= nxt(m[i], int'(din_v[i]), int'(clr_v[i]), FC[i], MX[i]);
    end
  end

  task automatic chk(string nm, int i, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d",
               nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("dout", i, int'(dout_v[i]), m[i].lvl);
        chk("rise", i, int'(rise_v[i]), m[i].rise);
        chk("fall", i, int'(fall_v[i]), m[i].fall);
        chk("busy", i, int'(busy_v[i]), m[i].busy);
        chk("edge_cnt", i, o_cnt[i], m[i].cnt);
        chk("pulse_excl", i, int'(rise_v[i] & fall_v[i]), 0);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    chk_en = 1'b0;
    din_v = 3'b100;
    clr_v = 3'b000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // reset held while din toggles
    for (int j = 0; j < 4; j++) begin
      din_v = 3'(j[0] ? 3'b011 : 3'b100);
      tick(1);
      chk("t1_dout", 0, int'(dout_v[0]), 0);
      chk("t1_busy", 0, int'(busy_v[0]), 0);
      chk("t1_dout", 2, int'(dout_v[2]), 1);
    end
    din_v = 3'b100;
    rst_n = 1'b1;
    tick(2);

    // clean rise on A
    din_v[0] = 1'b1;
    tick(1);
    chk("t2_busy_k", 0, int'(busy_v[0]), 1);
    tick(2);
    chk("t2_busy_k2", 0, int'(busy_v[0]), 1);
    chk("t2_dout_k2", 0, int'(dout_v[0]), 0);
    tick(1);
    chk("t2_dout", 0, int'(dout_v[0]), 1);
    chk("t2_rise", 0, int'(rise_v[0]), 1);
    chk("t2_cnt", 0, int'(ec0), 1);
    tick(1);
    chk("t2_rise_end", 0, int'(rise_v[0]), 0);

    // 3-sample low dip while high
    din_v[0] = 1'b0;
    tick(3);
    chk("t3_dip_busy", 0, int'(busy_v[0]), 1);
    din_v[0] = 1'b1;
    tick(1);
    chk("t3_dip_dout", 0, int'(dout_v[0]), 1);
    chk("t3_dip_busy0", 0, int'(busy_v[0]), 0);
    din_v[0] = 1'b0;
    tick(5);
    chk("t3_fall_dout", 0, int'(dout_v[0]), 0);
    chk("t3_fall_cnt", 0, int'(ec0), 2);
    // 3-sample high glitch while low
    din_v[0] = 1'b1;
    tick(3);
    din_v[0] = 1'b0;
    tick(1);
    chk("t3_gl_dout", 0, int'(dout_v[0]), 0);
    chk("t3_gl_busy", 0, int'(busy_v[0]), 0);
    chk("t3_gl_cnt", 0, int'(ec0), 2);

    // saturation on the 2-bit counter
    for (int j = 0; j < 5; j++) begin
      din_v[1] = ~din_v[1];
      tick(5);
    end
    chk("t4_sat", 1, int'(ec1), 3);
    chk("t4_dout", 1, int'(dout_v[1]), 1);
    din_v[1] = 1'b0;
    tick(3);
    clr_v[1] = 1'b1;
    tick(1);
    clr_v[1] = 1'b0;
    chk("t4_clr_acc", 1, int'(ec1), 1);
    chk("t4_clr_fall", 1, int'(fall_v[1]), 1);
    clr_v[1] = 1'b1;
    tick(1);
    clr_v[1] = 1'b0;
    chk("t4_clr", 1, int'(ec1), 0);

    // single-sample filter, reset level high
    din_v[2] = 1'b0;
    tick(1);
    chk("t5_dout", 2, int'(dout_v[2]), 0);
    chk("t5_fall", 2, int'(fall_v[2]), 1);
    chk("t5_cnt", 2, int'(ec2), 1);

    // random held levels on all three instances
    for (int j = 0; j < 80; j++) begin
      din_v = 3'($urandom);
      clr_v = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      tick($urandom_range(1, 6));
    end
    clr_v = 3'b000;
    din_v = 3'b100;
    tick(6);

    // reset during qualification
    din_v[0] = 1'b1;
    tick(2);
    chk("t6_busy_pre", 0, int'(busy_v[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", 0, int'(busy_v[0]), 0);
    chk("t6_dout_rst", 0, int'(dout_v[0]), 0);
    chk("t6_cnt_rst", 0, int'(ec0), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("t6_dout_3", 0, int'(dout_v[0]), 0);
    chk("t6_rise_3", 0, int'(rise_v[0]), 0);
    tick(1);
    chk("t6_dout_4", 0, int'(dout_v[0]), 1);
    chk("t6_rise_4", 0, int'(rise_v[0]), 1);
    tick(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
